// File: rtl/rv32m_divider_if.sv
// rv32m_divider_if: start/operand/result handshake between the execute stage and the divider.
interface rv32m_divider_if #(parameter int Width = 32);
  logic             start;
  logic [1:0]       op;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic             kill;
  logic             busy;
  logic             done;
  logic [Width-1:0] Q;
  modport master (output start, op, A, B, kill, input busy, done, Q);
  modport slave  (input start, op, A, B, kill, output busy, done, Q);
endinterface

// File: rtl/rv32m_divider.sv
// rv32m_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN finishes |A| < |B| in one cycle instead of Width iterations.
module rv32m_divider #(parameter int Width = 32) (
  input  logic clk,
  input  logic rst_n,
  rv32m_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(Width);
  localparam logic [Width-1:0] MIN_INT = {1'b1, {(Width-1){1'b0}}};
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic neg_q, neg_r, sgn, a_neg, b_neg, b_zero, ovf, early, special, last, fit;
  logic [Width-1:0] ma, mb, spec_q, rem, quo, dvs, rem_n, quo_n, res, q;
  logic [Width:0] rem_sh, diff;
  assign sgn     = ~bus.op[0];
  assign a_neg   = sgn & bus.A[Width-1];
  assign b_neg   = sgn & bus.B[Width-1];
  assign ma      = a_neg ? -bus.A : bus.A;
  assign mb      = b_neg ? -bus.B : bus.B;
  assign b_zero  = bus.B == '0;
  assign ovf     = sgn && bus.A == MIN_INT && bus.B == '1;
`ifdef DIV_EARLY_OUT_EN
  assign early   = !b_zero && ma < mb;
`else
  assign early   = 1'b0;
`endif
  assign special = b_zero | ovf | early;
  assign spec_q  = b_zero ? (bus.op[1] ? bus.A : '1) :
                   ovf    ? (bus.op[1] ? '0 : MIN_INT) :
                            (bus.op[1] ? bus.A : '0);
  // restoring step on a Width+1 bit partial remainder so the compare/subtract never overflows
  assign rem_sh  = {rem, quo[Width-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign fit     = rem_sh >= {1'b0, dvs};
  assign rem_n   = fit ? diff[Width-1:0] : rem_sh[Width-1:0];
  assign quo_n   = {quo[Width-2:0], fit};
  assign res     = op_q[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
  assign last    = cnt == CW'(Width - 1);
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.Q    = q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (bus.kill)                       state_nxt = IDLE;
    else if (state == IDLE && bus.start) state_nxt = special ? DONE : CALC;
    else if (state == CALC && last)      state_nxt = DONE;
    else if (state == DONE)              state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q     <= '0;
    end else if (!bus.kill) begin
      if (state == IDLE && bus.start) begin
        op_q  <= bus.op;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        rem   <= '0;
        quo   <= ma;
        dvs   <= mb;
        cnt   <= '0;
        if (special) q <= spec_q;
      end else if (state == CALC) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (last) q <= res;
      end
    end
endmodule

// File: tb/tb_rv32m_divider.sv
// tb_rv32m_divider: scoreboard bench for rv32m_divider covering latency, signs, special cases, kill and reset.
module tb_rv32m_divider;
  typedef struct {logic [31:0] q; int cyc;} exp_t;
`ifdef DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_q = '0;
  exp_t sb[$];
  rv32m_divider_if #(.Width(32)) bus ();
  rv32m_divider #(.Width(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.done) begin
      if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("q", bus.Q, e.q);
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", {31'd0, bus.busy}, 32'd1);
        last_q = e.q;
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 60) begin
      step();
      n++;
    end
    check("idle", {31'd0, bus.busy}, 32'd0);
  endtask
  task automatic drive(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
  endtask
  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int lat);
    step();
    drive(op, a, b);
    sb.push_back('{exp, cyc + lat});
    step();
    bus.start = 1'b0;
    check("busy_cycle1", {31'd0, bus.busy}, 32'd1);
    wait_idle();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_q", bus.Q, 32'd0);
    rst_n = 1'b1;
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33);
    issue(2'b00, -32'sd7, 32'd2, -32'sd3, 33);
    issue(2'b10, -32'sd7, 32'd2, -32'sd1, 33);
    issue(2'b11, -32'sd7, 32'd2, 32'd1, 33);
    issue(2'b01, -32'sd7, 32'd2, 32'h7FFF_FFFC, 33);
    issue(2'b00, 32'd7, -32'sd2, -32'sd3, 33);
    issue(2'b10, 32'd7, -32'sd2, 32'd1, 33);
    issue(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    issue(2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 33);
    issue(2'b01, 32'd42, 32'd0, 32'hFFFF_FFFF, 1);
    issue(2'b10, -32'sd42, 32'd0, -32'sd42, 1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    issue(2'b01, 32'd5, 32'd9, 32'd0, EL);
    issue(2'b10, -32'sd5, 32'd9, -32'sd5, EL);
    // kill mid-operation, then restart in the very next cycle
    step();
    drive(2'b01, 32'd1000, 32'd3);
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_q_held", bus.Q, last_q);
    drive(2'b01, 32'd1000, 32'd3);
    sb.push_back('{32'd333, cyc + 33});
    step();
    bus.start = 1'b0;
    wait_idle();
    // start held during an operation must be ignored
    step();
    drive(2'b01, 32'd100, 32'd7);
    sb.push_back('{32'd14, cyc + 33});
    step();
    drive(2'b01, 32'd9, 32'd3);
    repeat (4) step();
    bus.start = 1'b0;
    wait_idle();
    // kill together with start in IDLE drops the start
    step();
    drive(2'b01, 32'd9, 32'd0);
    bus.kill = 1'b1;
    step();
    bus.start = 1'b0;
    bus.kill = 1'b0;
    check("kill_start_busy", {31'd0, bus.busy}, 32'd0);
    // async reset mid-operation
    step();
    drive(2'b01, 32'd1000, 32'd3);
    step();
    bus.start = 1'b0;
    repeat (18) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_q", bus.Q, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
